// File: rtl/smarthouse_pkg.sv
// Shared smarthouse definitions: config/password widths and the arbiter FSM encoding.
package smarthouse_pkg;

  localparam int unsigned CFG_W = 35;
  localparam int unsigned PW_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage : smarthouse_pkg

// File: rtl/config_access_arbiter_if.sv
// Panel-side and ControlUnit-side signal bundle of the config access arbiter.
interface config_access_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CFG_W = 35
);
  import smarthouse_pkg::*;

  logic [N-1:0]         req;
  logic [N-1:0]         confirm_in;
  logic [PW_W*N-1:0]    password_in;
  logic [CFG_W*N-1:0]   config_in;
  logic                 cu_request;
  logic                 cu_confirm;
  logic [PW_W-1:0]      cu_password;
  logic [CFG_W-1:0]     cu_configin;
  logic                 cu_write_en;
  logic [N-1:0]         grant;
  logic [N-1:0]         done;
  logic                 timeout_err;

  // arbiter side
  modport slave (
    input  req, confirm_in, password_in, config_in, cu_write_en,
    output cu_request, cu_confirm, cu_password, cu_configin, grant, done, timeout_err
  );

  // panels + ControlUnit side
  modport master (
    output req, confirm_in, password_in, config_in, cu_write_en,
    input  cu_request, cu_confirm, cu_password, cu_configin, grant, done, timeout_err
  );

endinterface : config_access_arbiter_if

// File: rtl/config_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // scan ptr, ptr+1, ... and keep the first hit
  always_comb begin
    int unsigned c;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    c      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = IDX_W'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/config_access_arbiter.sv
// Round-robin arbiter sharing the ControlUnit auth/config-write path between N panels.
module config_access_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned CFG_W   = 35,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   arst,
  config_access_arbiter_if.slave bus,
  output logic [1:0]             dbg_state
);
  import smarthouse_pkg::*;

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     grant_q;
  logic [N-1:0]     done_q;
  logic             timeout_q;
  logic             request_q;
  logic             fire_done;
  logic             fire_to;

  logic [N-1:0]     pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // next-state: write_en beats req drop, which beats timeout
  always_comb begin
    state_nxt = state;
    fire_done = 1'b0;
    fire_to   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.cu_write_en) begin
          state_nxt = ST_RELEASE;
          fire_done = 1'b1;
        end else if (!bus.req[owner]) begin
          state_nxt = ST_RELEASE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_RELEASE;
          fire_to   = 1'b1;
        end
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // state, ownership, pointer, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      request_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_q    <= fire_done ? grant_q : '0;
      timeout_q <= fire_to;
      request_q <= (state_nxt == ST_BUSY);
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner   <= pick_idx;
            grant_q <= pick_onehot;
            cnt     <= '0;
          end
        end
        ST_BUSY: begin
          if (state_nxt == ST_RELEASE) begin
            grant_q <= '0;
            ptr     <= (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // forward the owner's inputs; an all-zero grant yields all-zero outputs
  always_comb begin
    bus.cu_confirm  = 1'b0;
    bus.cu_password = '0;
    bus.cu_configin = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        bus.cu_confirm  = bus.cu_confirm  | bus.confirm_in[i];
        bus.cu_password = bus.cu_password | bus.password_in[PW_W*i +: PW_W];
        bus.cu_configin = bus.cu_configin | bus.config_in[CFG_W*i +: CFG_W];
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_q;
  assign bus.cu_request  = request_q;
  assign dbg_state       = state;

endmodule : config_access_arbiter
